ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the 5-stage MIPS pipeline. It consumes the ID/EX pipeline register outputs, applies forwarding, and evaluates the ALU operation. It produces the result, store data, destination register and zero flag for the EX/MEM register. It also contains an iterative multiply/divide unit with HI/LO registers, which raises a stall request while busy.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width.
- `MD_CYCLES`, default 32: iteration count of the multiply/divide unit. Must equal `DATA_W`.

Ports:
- `clk`, input, 1: clock. All state updates on the falling edge, matching the pipeline registers.
- `rst`, input, 1: reset, asynchronous, active-high.
- `X_readData1`, `X_readData2`, `X_signExtend`, input, 32: operands from ID/EX.
- `X_rt`, `X_rd`, input, 5: destination candidates.
- `X_EX`, input, 4: {RegDst, ALUop[1:0], ALUsrc}.
- `X_funct`, input, 6: R-type function field.
- `forwardA`, `forwardB`, input, 2: forwarding selects. 00 selects the register file value, 10 selects `M_aluResult`, 01 selects `W_writeData`, 11 is treated as 00.
- `M_aluResult`, `W_writeData`, input, 32: forwarded values.
- `E_aluResult`, output, 32: ALU or mfhi/mflo result.
- `E_writeData`, output, 32: forwarded B operand, used as store data.
- `E_writeReg`, output, 5: `X_rd` if RegDst=1, else `X_rt`.
- `E_zero`, output, 1: asserted when `E_aluResult` equals 0.
- `E_busy`, output, 1: stall request to the hazard unit. While asserted, PC, IF/ID and ID/EX hold.

## Operation
- Operand A is the forwarded `readData1`.
- Operand B is `X_signExtend` if ALUsrc=1, else the forwarded `readData2`.
- ALUop decoding:
  - 00: add.
  - 01: sub.
  - 11: or.
  - 10: decode `X_funct`:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed).
    - 0x10 mfhi, 0x12 mflo.
    - 0x18 mult, 0x19 multu, 0x1A div, 0x1B divu.
    - Any other funct gives a result of 0.
- Add and sub wrap modulo 2^32; there is no overflow trap.
- mult/div instructions produce `E_aluResult`=0. The mult/div unit writes only HI/LO.
- Mult/div FSM states are IDLE, MUL, DIV and DONE.
  - IDLE: if a mult/div funct is present (ALUop=10), latch operand magnitudes and the signedness, set count=0, and go to MUL or DIV.
  - MUL: one radix-2 shift-add step per cycle.
  - DIV: one restoring shift-subtract step per cycle.
  - When count reaches `MD_CYCLES`-1, apply sign correction, write HI/LO, and go to DONE.
  - DONE: return to IDLE on the next edge, when the instruction leaves EX.
- `E_busy` is asserted when the FSM is in MUL or DIV, or when it is in IDLE and a mult/div funct is present. It is deasserted in DONE.
- Signed sign correction:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ.
  - Remainder takes the sign of the dividend.
- Result placement: mult puts the low word in LO and the high word in HI. div puts the quotient in LO and the remainder in HI.
- Divide by zero (signed or unsigned) takes the normal latency and returns LO=0xFFFFFFFF, HI=dividend operand unchanged.
- mfhi/mflo read the HI/LO register values. If mfhi/mflo is issued directly after a mult/div, it reads the updated values, because the write happens before DONE.

## Timing
- ALU path, forwarding and `E_writeReg` are combinational with zero latency.
- Mult/div timing:
  - Cycle 0 is IDLE with the instruction present; operands are latched at the end of that cycle.
  - Cycles 1..`MD_CYCLES` are MUL or DIV.
  - Cycle `MD_CYCLES`+1 is DONE.
  - `E_busy` is high for exactly `MD_CYCLES`+1 cycles.
- Operands are latched once, so forwarded values that change during the stall are ignored.
- Reset values: HI=0, LO=0, FSM=IDLE, count=0. Combinational outputs follow the inputs; with ID/EX cleared, `E_aluResult`=0, `E_zero`=1, `E_busy`=0.
- Reset mid-operation aborts the operation. HI/LO clear to 0 and no partial result is written.
- An ID/EX flush during a mult/div operation is not possible, because the stall holds ID/EX.

## Configuration
- `EX_MULDIV_EN` defined: the mult/div unit and the HI/LO registers are built.
- `EX_MULDIV_EN` undefined:
  - Funct codes 0x10, 0x12, 0x18, 0x19, 0x1A and 0x1B give a result of 0.
  - `E_busy` is tied to 0.
  - No HI/LO registers and no FSM are built.

## Structure
- Shared package `ex_pkg`:
  - ALUop codes.
  - Funct constants.
  - Forward select codes.
  - Mult/div state enum.
- One sub-module, `ex_muldiv_unit`, containing the FSM, datapath and HI/LO. Its ports are `clk`, `rst`, `start`, `op[1:0]`, `a`, `b`, `hi`, `lo` and `busy`.

## Test plan
- Forwarding: ALUop=10, funct 0x20, readData1=1, forwardA=10 with `M_aluResult`=5, readData2=7 → `E_aluResult`=12.
- Branch compare: ALUop=01, A=B=0x1234 → `E_aluResult`=0 and `E_zero`=1. Repeat with the values of `E_writeReg` for RegDst=0 and RegDst=1.
- Signed multiply: mult -3×5 → `E_busy` high for 33 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFF1. A following mflo returns 0xFFFFFFF1.
- Signed divide: div -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: divu 7/0 → LO=0xFFFFFFFF, HI=7, with normal latency.
- Reset mid-operation: assert `rst` at cycle 10 of a multu → `E_busy` drops and HI=LO=0. Re-issuing the multu completes correctly.

Source files
------------

// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the MIPS execute stage (ALUop, funct, forwarding, mult/div FSM).
package ex_pkg;
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {MD_IDLE, MD_MUL, MD_DIV, MD_DONE} md_state_e;
endpackage

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative radix-2 multiply / restoring divide on magnitudes, HI/LO registers.
module ex_muldiv_unit
    import ex_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              busy
);
    localparam int CW = MD_CYCLES > 1 ? $clog2(MD_CYCLES) : 1;

    md_state_e           state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2*DATA_W-1:0] p_q, p_d, p_step, prod;
    logic [DATA_W-1:0]   m_q, m_d, hi_q, hi_d, lo_q, lo_d, ua, ub, quo, rem;
    logic                neg_q, neg_d, negr_q, negr_d, div0_q, div0_d, sa, sb, last;
    logic [DATA_W:0]     sum, shl, diff;

    // op[1] selects divide, op[0] selects the unsigned variant
    assign sa   = ~op[0] & a[DATA_W-1];
    assign sb   = ~op[0] & b[DATA_W-1];
    assign ua   = sa ? -a : a;
    assign ub   = sb ? -b : b;
    assign last = cnt_q == CW'(MD_CYCLES - 1);

    // p_q holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
    assign sum    = {1'b0, p_q[2*DATA_W-1:DATA_W]} + (p_q[0] ? {1'b0, m_q} : '0);
    assign shl    = p_q[2*DATA_W-1:DATA_W-1];
    assign diff   = shl - {1'b0, m_q};
    assign p_step = state_q == MD_MUL ? {sum, p_q[DATA_W-1:1]}
                  : diff[DATA_W]      ? {shl[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                  :                     {diff[DATA_W-1:0], p_q[DATA_W-2:0], 1'b1};
    assign prod   = neg_q ? -p_step : p_step;
    // divide by zero leaves the dividend in the remainder; only the quotient needs forcing
    assign quo    = div0_q ? '1 : neg_q ? -p_step[DATA_W-1:0] : p_step[DATA_W-1:0];
    assign rem    = negr_q ? -p_step[2*DATA_W-1:DATA_W] : p_step[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        m_d     = m_q;
        neg_d   = neg_q;
        negr_d  = negr_q;
        div0_d  = div0_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: if (start) begin
                state_d = op[1] ? MD_DIV : MD_MUL;
                cnt_d   = '0;
                p_d     = {{DATA_W{1'b0}}, op[1] ? ua : ub};
                m_d     = op[1] ? ub : ua;
                neg_d   = sa ^ sb;
                negr_d  = sa;
                div0_d  = op[1] & ~|b;
            end
            MD_MUL, MD_DIV: begin
                p_d   = p_step;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d      = MD_DONE;
                    {hi_d, lo_d} = state_q == MD_MUL ? prod : {rem, quo};
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            p_q     <= '0;
            m_q     <= '0;
            neg_q   <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            m_q     <= m_d;
            neg_q   <= neg_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = state_q == MD_MUL || state_q == MD_DIV || (state_q == MD_IDLE && start);
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: rtl/ex_stage.sv
// ex_stage: MIPS EX stage - operand forwarding, ALU, destination select, optional mult/div.
// Define EX_MULDIV_EN to build the mult/div unit with HI/LO and the busy stall.
module ex_stage
    import ex_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] X_readData1,
    input  logic [DATA_W-1:0] X_readData2,
    input  logic [DATA_W-1:0] X_signExtend,
    input  logic [4:0]        X_rt,
    input  logic [4:0]        X_rd,
    input  logic [3:0]        X_EX,
    input  logic [5:0]        X_funct,
    input  logic [1:0]        forwardA,
    input  logic [1:0]        forwardB,
    input  logic [DATA_W-1:0] M_aluResult,
    input  logic [DATA_W-1:0] W_writeData,
    output logic [DATA_W-1:0] E_aluResult,
    output logic [DATA_W-1:0] E_writeData,
    output logic [4:0]        E_writeReg,
    output logic              E_zero,
    output logic              E_busy
);
    logic [1:0]        alu_op;
    logic [DATA_W-1:0] op_a, op_b, alu;

    assign alu_op      = X_EX[2:1];
    assign op_a        = forwardA == FWD_MEM ? M_aluResult : forwardA == FWD_WB ? W_writeData : X_readData1;
    assign E_writeData = forwardB == FWD_MEM ? M_aluResult : forwardB == FWD_WB ? W_writeData : X_readData2;
    assign op_b        = X_EX[0] ? X_signExtend : E_writeData;
    assign E_writeReg  = X_EX[3] ? X_rd : X_rt;

`ifdef EX_MULDIV_EN
    logic [DATA_W-1:0] hi, lo;

    ex_muldiv_unit #(.DATA_W(DATA_W), .MD_CYCLES(MD_CYCLES)) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (alu_op == ALUOP_RTYPE && X_funct inside {F_MULT, F_MULTU, F_DIV, F_DIVU}),
        .op    (X_funct[1:0]),
        .a     (op_a),
        .b     (op_b),
        .hi    (hi),
        .lo    (lo),
        .busy  (E_busy)
    );
`else
    logic unused_clk_rst;

    assign unused_clk_rst = clk ^ rst;
    assign E_busy         = 1'b0;
`endif

    // mult/div functs fall through to the default and return 0
    always_comb begin
        alu = '0;
        if (alu_op == ALUOP_ADD) alu = op_a + op_b;
        else if (alu_op == ALUOP_SUB) alu = op_a - op_b;
        else if (alu_op == ALUOP_OR) alu = op_a | op_b;
        else
            case (X_funct)
                F_ADD:   alu = op_a + op_b;
                F_SUB:   alu = op_a - op_b;
                F_AND:   alu = op_a & op_b;
                F_OR:    alu = op_a | op_b;
                F_NOR:   alu = ~(op_a | op_b);
                F_SLT:   alu = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
`ifdef EX_MULDIV_EN
                F_MFHI:  alu = hi;
                F_MFLO:  alu = lo;
`endif
                default: alu = '0;
            endcase
    end

    assign E_aluResult = alu;
    assign E_zero      = ~|alu;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: scoreboard bench for ex_stage; mult/div vectors are built with EX_MULDIV_EN.
module tb_ex_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rd1, rd2, se, m_res, w_res, res, wd;
    logic [4:0]  rt, rd, wr;
    logic [3:0]  ex;
    logic [5:0]  funct;
    logic [1:0]  fa, fb;
    logic        z, busy;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .X_readData1  (rd1),
        .X_readData2  (rd2),
        .X_signExtend (se),
        .X_rt         (rt),
        .X_rd         (rd),
        .X_EX         (ex),
        .X_funct      (funct),
        .forwardA     (fa),
        .forwardB     (fb),
        .M_aluResult  (m_res),
        .W_writeData  (w_res),
        .E_aluResult  (res),
        .E_writeData  (wd),
        .E_writeReg   (wr),
        .E_zero       (z),
        .E_busy       (busy)
    );

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [31:0] wd;
        logic [4:0]  wr;
        logic        busy;
    } exp_t;

    exp_t sb_q[$];
    int   busy_q[$];
    int   errors = 0, checks = 0, run = 0;
    logic chk = 1'b0, busy_s = 1'b0;

    // output monitor: one comparison per issued vector, sampled mid-cycle
    always @(posedge clk) begin
        exp_t e;
        if (chk) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                e = sb_q.pop_front();
                if (res !== e.res || wd !== e.wd || wr !== e.wr || z !== (e.res == 32'h0) || busy !== e.busy) begin
                    errors++;
                    $display("FAIL %s: got res=%h wd=%h wr=%0d zero=%b busy=%b, want res=%h wd=%h wr=%0d zero=%b busy=%b",
                             e.name, res, wd, wr, z, busy, e.res, e.wd, e.wr, e.res == 32'h0, e.busy);
                end
            end
        end
    end

    // busy-length monitor: compares each completed busy run against the queued length
    always @(posedge clk) begin
        int e;
        if (busy) run++;
        else if (run > 0) begin
            checks++;
            if (busy_q.size() == 0) begin
                errors++;
                $display("FAIL busy_len: got %0d busy cycles, want none", run);
            end else begin
                e = busy_q.pop_front();
                if (run != e) begin
                    errors++;
                    $display("FAIL busy_len: got %0d busy cycles, want %0d", run, e);
                end
            end
            run = 0;
        end
    end

    task automatic issue(input string name, input logic [3:0] x, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                         input logic [1:0] ffa, input logic [1:0] ffb,
                         input logic [31:0] mr, input logic [31:0] wb,
                         input logic [31:0] e_res, input logic [31:0] e_wd,
                         input logic [4:0] e_wr, input logic e_busy);
        exp_t e;
        #1;
        ex = x; funct = f; rd1 = a; rd2 = b; se = s; fa = ffa; fb = ffb; m_res = mr; w_res = wb;
        e.name = name; e.res = e_res; e.wd = e_wd; e.wr = e_wr; e.busy = e_busy;
        sb_q.push_back(e);
        chk = 1'b1;
        @(posedge clk);
        busy_s = busy;
        #1 chk = 1'b0;
        @(negedge clk);
    endtask

    // models the pipeline stall: ID/EX holds while busy was seen
    task automatic hold();
        int n = 0;
        while (busy_s && n < 100) begin
            @(posedge clk);
            busy_s = busy;
            @(negedge clk);
            n++;
        end
        if (busy_s) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: busy=1 after %0d cycles, want 0", n);
        end
    endtask

    localparam logic [3:0] R = 4'b1100;

    initial begin
        ex = '0; funct = '0; rd1 = '0; rd2 = '0; se = '0; fa = '0; fb = '0;
        m_res = '0; w_res = '0; rt = '0; rd = '0;
        issue("reset", 4'b0000, 6'h00, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd0, 1'b0);
        rst = 1'b0;
        rt = 5'd3;
        rd = 5'd9;
        issue("fwd_mem",   R, 6'h20, 32'd1, 32'd7, '0, 2'b10, 2'b00, 32'd5, '0, 32'd12, 32'd7, 5'd9, 1'b0);
        issue("beq_rt",    4'b0010, 6'h00, 32'h1234, 32'h1234, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h1234, 5'd3, 1'b0);
        issue("beq_rd",    4'b1010, 6'h00, 32'h1234, 32'h1234, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h1234, 5'd9, 1'b0);
        issue("fwd_wb",    R, 6'h22, 32'd10, 32'd99, '0, 2'b00, 2'b01, '0, 32'd3, 32'd7, 32'd3, 5'd9, 1'b0);
        issue("fwd_11",    R, 6'h20, 32'd4, 32'd6, '0, 2'b11, 2'b11, 32'd100, 32'd200, 32'd10, 32'd6, 5'd9, 1'b0);
        issue("and",       R, 6'h24, 32'hF0F01234, 32'h0FF0FF00, '0, 2'b00, 2'b00, '0, '0, 32'h00F01200, 32'h0FF0FF00, 5'd9, 1'b0);
        issue("or",        R, 6'h25, 32'hF0000000, 32'h0000000F, '0, 2'b00, 2'b00, '0, '0, 32'hF000000F, 32'h0000000F, 5'd9, 1'b0);
        issue("nor",       R, 6'h27, 32'h0F0F0F0F, 32'hF0F0F0F0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'hF0F0F0F0, 5'd9, 1'b0);
        issue("slt_true",  R, 6'h2A, 32'hFFFFFFFF, 32'd1, '0, 2'b00, 2'b00, '0, '0, 32'd1, 32'd1, 5'd9, 1'b0);
        issue("slt_false", R, 6'h2A, 32'd1, 32'hFFFFFFFF, '0, 2'b00, 2'b00, '0, '0, 32'd0, 32'hFFFFFFFF, 5'd9, 1'b0);
        issue("add_wrap",  R, 6'h20, 32'hFFFFFFFF, 32'd2, '0, 2'b00, 2'b00, '0, '0, 32'd1, 32'd2, 5'd9, 1'b0);
        issue("addi",      4'b0001, 6'h3F, 32'h100, 32'h55, 32'hFFFFFFFC, 2'b00, 2'b00, '0, '0, 32'hFC, 32'h55, 5'd3, 1'b0);
        issue("ori",       4'b0111, 6'h00, 32'hA0, 32'h0, 32'h0F, 2'b00, 2'b00, '0, '0, 32'hAF, 32'h0, 5'd3, 1'b0);
        issue("sub_op01",  4'b0010, 6'h00, 32'd5, 32'd8, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFD, 32'd8, 5'd3, 1'b0);
        issue("bad_funct", R, 6'h03, 32'd5, 32'd6, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd6, 5'd9, 1'b0);
        issue("mfhi_rst",  R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd9, 1'b0);
`ifdef EX_MULDIV_EN
        busy_q.push_back(33);
        issue("mult", R, 6'h18, 32'hFFFFFFFD, 32'd5, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd5, 5'd9, 1'b1);
        hold();
        issue("mult_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFF1, 32'h0, 5'd9, 1'b0);
        issue("mult_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFF, 32'h0, 5'd9, 1'b0);
        busy_q.push_back(33);
        issue("div", R, 6'h1A, 32'hFFFFFFF9, 32'd2, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd2, 5'd9, 1'b1);
        hold();
        issue("div_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFD, 32'h0, 5'd9, 1'b0);
        issue("div_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFF, 32'h0, 5'd9, 1'b0);
        busy_q.push_back(33);
        issue("divu0", R, 6'h1B, 32'd7, 32'd0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd0, 5'd9, 1'b1);
        hold();
        issue("divu0_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFF, 32'h0, 5'd9, 1'b0);
        issue("divu0_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'd7, 32'h0, 5'd9, 1'b0);
        busy_q.push_back(33);
        issue("multu_max", R, 6'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'hFFFFFFFF, 5'd9, 1'b1);
        hold();
        issue("multu_max_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h00000001, 32'h0, 5'd9, 1'b0);
        issue("multu_max_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'hFFFFFFFE, 32'h0, 5'd9, 1'b0);
        busy_q.push_back(10);
        issue("multu_abort", R, 6'h19, 32'd6, 32'd7, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd7, 5'd9, 1'b1);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        issue("rst_mid", 4'b0000, 6'h00, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd3, 1'b0);
        rst = 1'b0;
        issue("abort_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd9, 1'b0);
        issue("abort_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd9, 1'b0);
        busy_q.push_back(33);
        issue("multu_redo", R, 6'h19, 32'd6, 32'd7, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd7, 5'd9, 1'b1);
        hold();
        issue("redo_lo", R, 6'h12, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'd42, 32'h0, 5'd9, 1'b0);
        issue("redo_hi", R, 6'h10, '0, '0, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'h0, 5'd9, 1'b0);
`else
        issue("mult_off", R, 6'h18, 32'hFFFFFFFD, 32'd5, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd5, 5'd9, 1'b0);
        issue("div_off",  R, 6'h1A, 32'hFFFFFFF9, 32'd2, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd2, 5'd9, 1'b0);
        issue("mflo_off", R, 6'h12, 32'd3, 32'd4, '0, 2'b00, 2'b00, '0, '0, 32'h0, 32'd4, 5'd9, 1'b0);
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0 || busy_q.size() != 0 || run != 0) begin
            errors++;
            $display("FAIL leftover: got %0d outputs, %0d busy runs pending, run=%0d, want 0/0/0",
                     sb_q.size(), busy_q.size(), run);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
